// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the ID-stage branch resolution unit:
// branch opcode constants and the resolution FSM state encoding.
package branch_resolve_pkg;

    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_OPS = 2'd1,
        DONE     = 2'd2
    } br_state_e;

endpackage

// File: rtl/branch_resolve_cond.sv
// Combinational branch condition and target evaluation.
// blez/bgtz/regimm compare rs against a fixed constant, not the rt operand.
module branch_cond
    import branch_resolve_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [4:0]  rt_field,
    input  logic        override_rt,
    input  logic [31:0] rt_val,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [31:0] pc_plus4,
    input  logic [15:0] imm,
    output logic        taken,
    output logic [31:0] target
);

    logic [31:0] op_b;
    logic        unused_rt_bits;

    assign unused_rt_bits = ^rt_field[4:1];

    always_comb begin
        op_b  = override_rt ? rt_val : rt_data;
        taken = 1'b0;
        case (opcode)
            OP_BEQ:    taken = (rs_data == op_b);
            OP_BNE:    taken = (rs_data != op_b);
            OP_BLEZ:   taken = ($signed(rs_data) <  32'sd1);
            OP_BGTZ:   taken = ($signed(rs_data) >= 32'sd1);
            OP_REGIMM: taken = rt_field[0] ? ($signed(rs_data) >= 32'sd0)
                                           : ($signed(rs_data) <  32'sd0);
            default:   taken = 1'b0;
        endcase
    end

    assign target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};

endmodule

// File: rtl/branch_resolve.sv
// ID-stage branch resolution: one-shot redirect/flush, operand-wait stall,
// double-resolution guard while ID is held, and saturating perf counters.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_advance,
    input  logic [5:0]       opcode,
    input  logic [4:0]       rt_field,
    input  logic             branch_op,
    input  logic             override_rt,
    input  logic [31:0]      rt_val,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    input  logic             rs_ready,
    input  logic             rt_ready,
    input  logic [31:0]      pc_plus4,
    input  logic [15:0]      imm,
    output logic             stall_id,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush_if,
    output logic             wait_timeout,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WAIT_W = (MAX_WAIT < 16) ? 4 : $clog2(MAX_WAIT + 1);

    br_state_e         state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              is_br, ops_ok;
    logic              resolve, stall_raw;
    logic              cond_taken;
    logic [31:0]       cond_target;

    branch_cond u_cond (
        .opcode      (opcode),
        .rt_field    (rt_field),
        .override_rt (override_rt),
        .rt_val      (rt_val),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .pc_plus4    (pc_plus4),
        .imm         (imm),
        .taken       (cond_taken),
        .target      (cond_target)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        is_br          = id_valid & branch_op;
        ops_ok         = rs_ready & (override_rt | rt_ready);
        state_nxt      = state;
        resolve        = 1'b0;
        stall_raw      = 1'b0;
        case (state)
            IDLE: begin
                if (is_br) begin
                    if (ops_ok) begin
                        resolve   = 1'b1;
                        state_nxt = id_advance ? IDLE : DONE;
                    end else begin
                        stall_raw = 1'b1;
                        state_nxt = WAIT_OPS;
                    end
                end
            end
            WAIT_OPS: begin
                // an external flush wins over operands arriving in the same cycle
                if (!id_valid) begin
                    state_nxt = IDLE;
                end else if (ops_ok) begin
                    resolve   = 1'b1;
                    state_nxt = id_advance ? IDLE : DONE;
                end else begin
                    stall_raw = 1'b1;
                end
            end
            DONE: begin
                if (id_advance || !id_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        stall_id       = stall_raw & ~rst;
        redirect_valid = resolve & cond_taken & ~rst;
        flush_if       = resolve & cond_taken & ~rst;
        redirect_pc    = (resolve && !rst) ? cond_target : '0;
        // fires during the MAX_WAIT-th WAIT_OPS cycle; the count then saturates
        wait_timeout   = (state == WAIT_OPS) && (wait_cnt == WAIT_W'(MAX_WAIT - 1)) && !rst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == IDLE && state_nxt == WAIT_OPS) begin
            wait_cnt <= '0;
        end else if (state == WAIT_OPS && wait_cnt != WAIT_W'(MAX_WAIT)) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt <= '0;
            taken_cnt  <= '0;
            stall_cnt  <= '0;
        end else begin
            if (resolve && branch_cnt != '1)
                branch_cnt <= branch_cnt + CNT_W'(1);
            if (resolve && cond_taken && taken_cnt != '1)
                taken_cnt <= taken_cnt + CNT_W'(1);
            if (stall_raw && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
